fp_normalize_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined normaliser for the FP add/sub datapath. Sits between mantissa add and rounding.

---
 rtl/fp_normalize_pipe.sv | 227 ++++++++++++++++++++++
 tb/tb_fp_normalize_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_pipe.sv
// fp_normalize_pipe: two-stage normaliser placed between the mantissa adder and
// the rounder of the FP add/sub datapath. Stage 1 captures the operands and the
// leading-zero count. Stage 2 applies the shift, extracts fraction/GRS and
// computes the exponent and the status flags. A valid/ready handshake is used
// on both sides, and flush kills every operation still in flight.
module fp_normalize_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SUM_W = 2*MAN_W+3,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             in_sticky,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [MAN_W-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [2:0]       out_grs,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic [TAG_W-1:0] out_tag
);

  // Bit H of the sum is the hidden bit; the bit above it is the carry-out.
  localparam int H    = SUM_W - 2;
  // The leading-zero count ranges over 0..H+1 (H+1 means bits H..0 are all zero).
  localparam int LZ_W = $clog2(H + 2);
  // Exponent arithmetic is done one bit wider so it can never wrap.
  localparam int XW   = EXP_W + 1;
  // Number of fraction bits below the round bit; they collapse into sticky.
  localparam int LO_W = H - MAN_W - 2;

  // Stage 1 registers
  logic             s1_valid_q;
  logic             s1_sign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [SUM_W-1:0] s1_sum_q;
  logic             s1_sticky_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [LZ_W-1:0]  s1_lz_q;
  logic [LZ_W-1:0]  s1_lz_d;

  // Stage 2 registers (these drive the outputs directly)
  logic             s2_valid_q;
  logic             s2_sign_q;
  logic [MAN_W-1:0] s2_mant_q;
  logic [MAN_W-1:0] s2_mant_d;
  logic [EXP_W-1:0] s2_exp_q;
  logic [EXP_W-1:0] s2_exp_d;
  logic [2:0]       s2_grs_q;
  logic [2:0]       s2_grs_d;
  logic             s2_zero_q;
  logic             s2_zero_d;
  logic             s2_ovf_q;
  logic             s2_ovf_d;
  logic             s2_unf_q;
  logic             s2_unf_d;
  logic [TAG_W-1:0] s2_tag_q;

  // Pipeline advance controls
  logic s2_load;
  logic s1_load;

  // Stage-2 datapath intermediates
  logic [XW-1:0]   eff;
  logic [XW-1:0]   lz_x;
  logic [XW-1:0]   exp_x;
  logic [LZ_W-1:0] shift_amt;
  logic [H-1:0]    frac;
  logic            lost_bit;
  logic            clamp;
  logic            guard_bit;
  logic            round_bit;
  logic            sticky_bit;

  // A stage may load when it is empty or when its contents move on this cycle.
  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = s1_load;
  end

  // Leading-zero count from the hidden bit downward; the highest set bit wins.
  always_comb begin
    s1_lz_d = LZ_W'(H + 1);
    for (int i = 0; i <= H; i++) begin
      if (in_sum[i]) begin
        s1_lz_d = LZ_W'(H - i);
      end
    end
  end

  // Valid bits: flush empties both stages, otherwise they follow the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
      end
    end
  end

  // Stage-1 operand capture, only when a new operation is actually taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_sum_q    <= '0;
      s1_sticky_q <= 1'b0;
      s1_tag_q    <= '0;
      s1_lz_q     <= '0;
    end else if (s1_load && in_valid) begin
      s1_sign_q   <= in_sign;
      s1_exp_q    <= in_exp;
      s1_sum_q    <= in_sum;
      s1_sticky_q <= in_sticky;
      s1_tag_q    <= in_tag;
      s1_lz_q     <= s1_lz_d;
    end
  end

  // Normalising shift, field extraction and flag generation for stage 2.
  always_comb begin
    eff        = (s1_exp_q == '0) ? XW'(1) : {1'b0, s1_exp_q};
    lz_x       = XW'(s1_lz_q);
    exp_x      = '0;
    shift_amt  = '0;
    lost_bit   = 1'b0;
    clamp      = 1'b0;
    // frac holds the bits below the extract point; the hidden bit is dropped.
    frac       = s1_sum_q[H-1:0];
    if (s1_sum_q[SUM_W-1]) begin
      // Carry-out: one position right; the bit falling off still counts as sticky.
      frac     = s1_sum_q[H:1];
      lost_bit = s1_sum_q[0];
      exp_x    = {1'b0, s1_exp_q} + XW'(1);
    end else if (lz_x < eff) begin
      // Full normalisation fits inside the exponent range.
      shift_amt = s1_lz_q;
      frac      = s1_sum_q[H-1:0] << shift_amt;
      exp_x     = eff - lz_x;
    end else begin
      // Would go below exponent 1: stop at the subnormal boundary.
      // eff-1 < lz here, so the amount fits in the lz width.
      shift_amt = LZ_W'(eff - XW'(1));
      frac      = s1_sum_q[H-1:0] << shift_amt;
      exp_x     = '0;
      clamp     = 1'b1;
    end

    guard_bit  = frac[LO_W+1];
    round_bit  = frac[LO_W];
    sticky_bit = (|frac[LO_W-1:0]) | s1_sticky_q | lost_bit;

    s2_mant_d = frac[H-1 -: MAN_W];
    s2_grs_d  = {guard_bit, round_bit, sticky_bit};
    s2_ovf_d  = (exp_x >= {1'b0, {EXP_W{1'b1}}});
    s2_exp_d  = exp_x[EXP_W] ? {EXP_W{1'b1}} : exp_x[EXP_W-1:0];
    s2_unf_d  = clamp && ((s2_mant_d != '0) || (s2_grs_d != 3'b000));
    s2_zero_d = 1'b0;

    // An all-zero sum overrides everything; only the alignment sticky survives.
    if (s1_sum_q == '0) begin
      s2_mant_d = '0;
      s2_exp_d  = '0;
      s2_grs_d  = {2'b00, s1_sticky_q};
      s2_zero_d = !s1_sticky_q;
      s2_ovf_d  = 1'b0;
      s2_unf_d  = 1'b0;
    end
  end

  // Stage-2 result registers; held while the downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_sign_q <= 1'b0;
      s2_mant_q <= '0;
      s2_exp_q  <= '0;
      s2_grs_q  <= '0;
      s2_zero_q <= 1'b0;
      s2_ovf_q  <= 1'b0;
      s2_unf_q  <= 1'b0;
      s2_tag_q  <= '0;
    end else if (s2_load && s1_valid_q) begin
      s2_sign_q <= s1_sign_q;
      s2_mant_q <= s2_mant_d;
      s2_exp_q  <= s2_exp_d;
      s2_grs_q  <= s2_grs_d;
      s2_zero_q <= s2_zero_d;
      s2_ovf_q  <= s2_ovf_d;
      s2_unf_q  <= s2_unf_d;
      s2_tag_q  <= s1_tag_q;
    end
  end

  // Outputs come straight from the stage-2 registers.
  always_comb begin
    out_valid     = s2_valid_q;
    out_sign      = s2_sign_q;
    out_mant      = s2_mant_q;
    out_exp       = s2_exp_q;
    out_grs       = s2_grs_q;
    out_zero      = s2_zero_q;
    out_overflow  = s2_ovf_q;
    out_underflow = s2_unf_q;
    out_tag       = s2_tag_q;
  end

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Bench for fp_normalize_pipe: directed cases with hand-computed results, then
// randomized traffic with backpressure and flushes scored against a queue of
// results computed by a value-level normalisation model.
module tb_fp_normalize_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [48:0] in_sum = '0;
  logic        in_sticky = 1'b0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [22:0] out_mant;
  logic [7:0]  out_exp;
  logic [2:0]  out_grs;
  logic        out_zero;
  logic        out_overflow;
  logic        out_underflow;
  logic [4:0]  out_tag;

  fp_normalize_pipe #(.EXP_W(8), .MAN_W(23), .SUM_W(49), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_sum(in_sum), .in_sticky(in_sticky), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_mant(out_mant), .out_exp(out_exp), .out_grs(out_grs),
    .out_zero(out_zero), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sign;
    logic [22:0] mant;
    logic [7:0]  ex;
    logic [2:0]  grs;
    logic        zero;
    logic        ovf;
    logic        unf;
    logic [4:0]  tag;
  } res_t;

  res_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Value-level reference: bring the most significant set bit to the hidden
  // position (bit 47) while keeping the exponent >= 1, then slice the fields.
  function automatic res_t model(input logic sg, input logic [7:0] e, input logic [48:0] s,
                                 input logic st, input logic [4:0] tg);
    res_t r;
    logic [63:0] v;
    int p, eff, lz, ex;
    logic lost;
    r = '0;
    r.sign = sg;
    r.tag = tg;
    if (s == 49'd0) begin
      r.grs = {2'b00, st};
      r.zero = !st;
      return r;
    end
    eff = (e == 8'd0) ? 1 : int'(e);
    p = 48;
    while (p > 0 && s[p] == 1'b0) p--;
    v = 64'(s);
    lost = 1'b0;
    if (p == 48) begin
      lost = s[0];
      v = v >> 1;
      ex = int'(e) + 1;
    end else begin
      lz = 47 - p;
      if (lz < eff) begin
        v = v << lz;
        ex = eff - lz;
      end else begin
        v = v << (eff - 1);
        ex = 0;
      end
    end
    r.mant = v[46:24];
    r.grs = {v[23], v[22], (v[21:0] != 22'd0) || st || lost};
    r.ex = (ex > 255) ? 8'hFF : 8'(ex);
    r.ovf = (ex >= 255);
    r.unf = (ex == 0) && ((r.mant != 23'd0) || (r.grs != 3'b000));
    return r;
  endfunction

  task automatic cmp_out(input res_t e);
    chk("sign", 64'(out_sign), 64'(e.sign));
    chk("mant", 64'(out_mant), 64'(e.mant));
    chk("exp", 64'(out_exp), 64'(e.ex));
    chk("grs", 64'(out_grs), 64'(e.grs));
    chk("zero", 64'(out_zero), 64'(e.zero));
    chk("overflow", 64'(out_overflow), 64'(e.ovf));
    chk("underflow", 64'(out_underflow), 64'(e.unf));
    chk("tag", 64'(out_tag), 64'(e.tag));
  endtask

  // One clock cycle: drive inputs after the falling edge, score the output side
  // (including stalled outputs against the pending head), record accepted ops.
  task automatic cycle(input logic v, input logic sg, input logic [7:0] e, input logic [48:0] s,
                       input logic st, input logic [4:0] tg, input logic ordy, input logic fl,
                       output logic acc);
    in_valid = v; in_sign = sg; in_exp = e; in_sum = s; in_sticky = st; in_tag = tg;
    out_ready = ordy; flush = fl;
    #1;
    if (out_valid) begin
      chk("out_valid_with_op_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        cmp_out(exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    acc = v && in_ready && !fl;
    if (acc) exp_q.push_back(model(sg, e, s, st, tg));
    if (fl) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    cycle(1'b0, 1'b0, 8'd0, 49'd0, 1'b0, 5'd0, ordy, 1'b0, acc);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
    chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Single op through an empty pipe: 2-cycle latency and hand-computed fields.
  task automatic directed(input string nm, input logic sg, input logic [7:0] e, input logic [48:0] s,
                          input logic st, input logic [4:0] tg, input logic [7:0] xe,
                          input logic [22:0] xm, input logic [2:0] xg, input logic [2:0] xf);
    logic acc;
    cycle(1'b1, sg, e, s, st, tg, 1'b1, 1'b0, acc);
    chk({nm, "_accept"}, 64'(acc), 64'd1);
    chk({nm, "_lat1_valid"}, 64'(out_valid), 64'd0);
    idle(1'b1);
    chk({nm, "_lat2_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_exp"}, 64'(out_exp), 64'(xe));
    chk({nm, "_mant"}, 64'(out_mant), 64'(xm));
    chk({nm, "_grs"}, 64'(out_grs), 64'(xg));
    chk({nm, "_flags"}, 64'({out_zero, out_overflow, out_underflow}), 64'(xf));
    chk({nm, "_sign"}, 64'(out_sign), 64'(sg));
    idle(1'b1);
  endtask

  initial begin
    logic acc;
    logic [63:0] r64;
    logic [48:0] s;
    logic [7:0] e;
    int idx;
    logic [48:0] bp_sum [4];

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_data", 64'({out_sign, out_mant, out_exp, out_grs, out_tag}), 64'd0);
    chk("rst_flags", 64'({out_zero, out_overflow, out_underflow}), 64'd0);
    reset = 1'b0;

    // Directed arithmetic cases
    directed("carry", 1'b0, 8'h80, 49'h1_8000_0000_0000, 1'b0, 5'd1, 8'h81, 23'h400000, 3'b000, 3'b000);
    directed("cancel", 1'b1, 8'h7F, 49'h100_0000_0000, 1'b0, 5'd2, 8'h78, 23'h000000, 3'b000, 3'b000);
    directed("subnorm", 1'b0, 8'h03, 49'h100_0000_0000, 1'b0, 5'd3, 8'h00, 23'h040000, 3'b000, 3'b001);
    directed("zero", 1'b0, 8'h40, 49'h0, 1'b0, 5'd4, 8'h00, 23'h000000, 3'b000, 3'b100);
    directed("zero_sticky", 1'b0, 8'h40, 49'h0, 1'b1, 5'd5, 8'h00, 23'h000000, 3'b001, 3'b000);
    directed("overflow", 1'b0, 8'hFE, 49'h1_0000_0000_0000, 1'b0, 5'd6, 8'hFF, 23'h000000, 3'b000, 3'b010);
    directed("carry_lost", 1'b0, 8'h10, 49'h1_0000_0000_0001, 1'b0, 5'd7, 8'h11, 23'h000000, 3'b001, 3'b000);
    directed("exp0_norm", 1'b0, 8'h00, 49'h0_8000_0000_0000, 1'b0, 5'd8, 8'h01, 23'h000000, 3'b000, 3'b000);

    // Backpressure: 4 back-to-back ops, out_ready low for cycles 1..3
    bp_sum[0] = 49'h0_C000_0000_0000; bp_sum[1] = 49'h0_1234_5678_9ABC;
    bp_sum[2] = 49'h1_FFFF_0000_0003; bp_sum[3] = 49'h0_0000_0F00_0000;
    idx = 0;
    for (int c = 0; c < 12 && idx < 4; c++) begin
      cycle(1'b1, 1'b0, 8'h90, bp_sum[idx], 1'b0, 5'(10 + idx), !(c >= 1 && c <= 3), 1'b0, acc);
      if (c == 2) chk("bp_in_ready_c2", 64'(acc), 64'd0);
      if (c == 3) chk("bp_in_ready_c3", 64'(acc), 64'd0);
      if (acc) idx++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd4);
    drain("bp");

    // Flush with two ops in flight; the same-cycle op is discarded
    cycle(1'b1, 1'b0, 8'h70, 49'h0_9000_0000_0000, 1'b0, 5'd20, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 8'h71, 49'h0_A000_0000_0000, 1'b0, 5'd21, 1'b1, 1'b0, acc);
    chk("pre_flush_valid", 64'(out_valid), 64'd1);
    cycle(1'b1, 1'b0, 8'h72, 49'h0_B000_0000_0000, 1'b0, 5'd22, 1'b0, 1'b1, acc);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    idle(1'b1);
    chk("flush_stays_empty", 64'(out_valid), 64'd0);
    cycle(1'b1, 1'b0, 8'h73, 49'h0_C000_0000_0001, 1'b0, 5'd23, 1'b1, 1'b0, acc);
    chk("postflush_accept", 64'(acc), 64'd1);
    chk("postflush_lat1", 64'(out_valid), 64'd0);
    idle(1'b1);
    chk("postflush_lat2", 64'(out_valid), 64'd1);
    chk("postflush_tag", 64'(out_tag), 64'd23);
    drain("flush");

    // Asynchronous reset while stalled: outputs clear without a clock edge
    cycle(1'b1, 1'b1, 8'h55, 49'h0_ABCD_EF01_2345, 1'b1, 5'd31, 1'b0, 1'b0, acc);
    idle(1'b0);
    chk("prereset_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_data", 64'({out_sign, out_mant, out_exp, out_grs, out_tag}), 64'd0);
    chk("async_rst_flags", 64'({out_zero, out_overflow, out_underflow}), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic with backpressure and occasional flush
    for (int n = 0; n < 500; n++) begin
      r64 = {$urandom(), $urandom()};
      case ($urandom_range(0, 9))
        0: s = 49'd0;
        1, 2, 3: s = r64[48:0] | (49'd1 << 48);
        default: s = r64[48:0] >> $urandom_range(1, 48);
      endcase
      e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 254));
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), e, s, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, acc);
    end
    drain("random");
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
